mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequencing controller and two-way arbiter in front of the single-port, byte-addressed `memory` model. It shares the port between the instruction-fetch requester (read-only line fill) and the data requester (line fill or masked write-back). It serialises their transactions and emulates a fixed main-memory latency with a countdown counter. It then issues exactly one single-cycle `op_en` access per transaction and returns the read line to the winner.

## Interface
Parameters:
- `ADDR_SIZE`, 32, address width (from PARAMS_pkg)
- `WD_SIZE`, 128, line width in bits, equals memory port width (from PARAMS_pkg)
- `MEM_LATENCY`, 5, cycles spent in BUSY per transaction; legal range 1..15

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `ic_req`  in  1  instruction fill request, level, held until `ic_rsp_valid`
- `ic_addr`  in  ADDR_SIZE  instruction fill address, stable while `ic_req`
- `ic_rsp_valid`  out  1  one-cycle pulse, fill complete
- `ic_rsp_data`  out  WD_SIZE  fill line, valid with `ic_rsp_valid`
- `dc_req`  in  1  data request, level, held until `dc_rsp_valid`
- `dc_rd_wr`  in  1  0 read, 1 write
- `dc_addr`  in  ADDR_SIZE  data address
- `dc_wr_data`  in  WD_SIZE  write line
- `dc_wr_keep`  in  WD_SIZE  per-bit keep mask; only whole bytes are honoured by memory
- `dc_rsp_valid`  out  1  one-cycle pulse, read or write complete
- `dc_rsp_data`  out  WD_SIZE  read line; all zeros for writes
- `mem_addr`  out  ADDR_SIZE  memory address
- `mem_op_rd_wr`  out  1  memory op, 0 rd, 1 wr
- `mem_op_en`  out  1  memory enable, high only in ACCESS
- `mem_wr_data`  out  WD_SIZE  memory write data
- `mem_wr_keep`  out  WD_SIZE  memory write keep mask
- `mem_rd_data`  in  WD_SIZE  memory read data, combinational from memory
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, BUSY, ACCESS, RESP.
- IDLE: requests are sampled only here.
  - No request: stay in IDLE.
  - Otherwise: grant per arbitration policy.
  - On grant, latch addr, op, wr_data and keep into the `mem_*` output registers. The icache always latches op = 0 and keep = 0.
  - On grant, record the winner, load the counter with `MEM_LATENCY`, and go to BUSY.
- BUSY: decrement the counter each cycle. Leave for ACCESS on the cycle the counter reads 1. BUSY therefore lasts exactly `MEM_LATENCY` cycles.
- ACCESS (1 cycle): `mem_op_en` = 1.
  - Read: capture `mem_rd_data` into the winner's response register at the clock edge.
  - Write: load zeros into the winner's response register.
  - Then go to RESP.
- RESP (1 cycle): raise the winner's `*_rsp_valid`, then go to IDLE.
- `*_rsp_data` holds its value until the next transaction for the same requester completes.
- Requester contract: drop `req` on the edge that ends its RESP cycle. Requests and their payloads must stay stable from assertion until `rsp_valid`.
- A request raised while the arbiter is not in IDLE waits; it is never lost or reordered within one requester.
- The `mem_*` address, op, data and keep registers hold their values outside ACCESS. Only `mem_op_en` qualifies them.
- The counter is 4 bits wide and never wraps: it is loaded only in IDLE and stops at 1.

## Timing
- Request first visible in IDLE at cycle T: BUSY occupies T+1..T+MEM_LATENCY, ACCESS is at T+MEM_LATENCY+1, and `rsp_valid` is at T+MEM_LATENCY+2.
- With the default latency this is 7 cycles.
- Back-to-back: the earliest next grant is in the IDLE cycle after RESP, at T+MEM_LATENCY+3. Throughput is one transaction per MEM_LATENCY+3 cycles.
- Simultaneous `ic_req` and `dc_req` in IDLE: exactly one grant; the loser is served in the next transaction.
- Reset, in any state including mid-transaction:
  - Next state is IDLE, the counter is 0 and the transaction is abandoned with no `rsp_valid`.
  - All outputs go to 0: `mem_op_en`, `mem_op_rd_wr`, `mem_addr`, `mem_wr_data`, `mem_wr_keep`, both `rsp_valid`, both `rsp_data` and `busy`.
  - The round-robin pointer is set so dcache wins the first tie.
- `mem_op_en` is never high during reset or in two consecutive cycles.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit last-grant pointer is updated on every grant.
  - On a tie, the requester not granted last wins.
- Undefined: fixed priority, dcache always beats icache. There is no pointer register, and icache can starve under continuous dcache traffic.

## Test plan
- Single icache read: memory preloaded with 0x00112233_44556677_8899AABB_CCDDEEFF at 0x40; `ic_req` with `ic_addr`=0x40 at cycle 0 → `mem_op_en` only at cycle 6 with `mem_op_rd_wr`=0; `ic_rsp_valid` pulse at cycle 7 with that line; `dc_rsp_valid` stays 0.
- Masked dcache write then read: write 0xFFFF…FF at 0x80 with keep set only on byte 0 → `dc_rsp_valid` at +7 with data 0. A following read of 0x80 returns a line whose byte 0 is 0xFF and whose other bytes keep their prior contents.
- Tie, `MEM_ARB_RR_EN` defined: both requests at cycle 0 → dc served first (rsp at 7) and ic second (rsp at 15). A repeated tie afterwards grants ic first.
- Tie, macro undefined: dc re-raises `req` immediately after each response → ic is never granted across 5 dc transactions; ic is granted after dc drops.
- Reset mid-BUSY: assert `reset` at cycle 3 of a dc read → next cycle `busy`=0, no `rsp_valid`, no `mem_op_en`. A new ic request after reset completes in 7 cycles.
- `MEM_LATENCY`=1: ic read → `mem_op_en` at cycle 2, `ic_rsp_valid` at cycle 3.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-way arbiter and latency-emulating sequencer in front of the single-port line memory.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise dcache has fixed priority.
module mem_arbiter #(
  parameter int ADDR_SIZE   = 32,
  parameter int WD_SIZE     = 128,
  parameter int MEM_LATENCY = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ic_req,
  input  logic [ADDR_SIZE-1:0] ic_addr,
  output logic                 ic_rsp_valid,
  output logic [WD_SIZE-1:0]   ic_rsp_data,
  input  logic                 dc_req,
  input  logic                 dc_rd_wr,
  input  logic [ADDR_SIZE-1:0] dc_addr,
  input  logic [WD_SIZE-1:0]   dc_wr_data,
  input  logic [WD_SIZE-1:0]   dc_wr_keep,
  output logic                 dc_rsp_valid,
  output logic [WD_SIZE-1:0]   dc_rsp_data,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic                 mem_op_rd_wr,
  output logic                 mem_op_en,
  output logic [WD_SIZE-1:0]   mem_wr_data,
  output logic [WD_SIZE-1:0]   mem_wr_keep,
  input  logic [WD_SIZE-1:0]   mem_rd_data,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY);
  localparam logic       WIN_IC   = 1'b0;
  localparam logic       WIN_DC   = 1'b1;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 win_q, win_d;
  logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic                 mem_op_rd_wr_q, mem_op_rd_wr_d;
  logic                 mem_op_en_q, mem_op_en_d;
  logic [WD_SIZE-1:0]   mem_wr_data_q, mem_wr_data_d;
  logic [WD_SIZE-1:0]   mem_wr_keep_q, mem_wr_keep_d;
  logic                 ic_rsp_valid_q, ic_rsp_valid_d;
  logic                 dc_rsp_valid_q, dc_rsp_valid_d;
  logic [WD_SIZE-1:0]   ic_rsp_data_q, ic_rsp_data_d;
  logic [WD_SIZE-1:0]   dc_rsp_data_q, dc_rsp_data_d;
  logic                 busy_q, busy_d;
  logic                 grant_dc_s;
`ifdef MEM_ARB_RR_EN
  logic                 rr_last_q, rr_last_d;
`endif

  // Arbitration decision, only consumed in IDLE
  always_comb begin
    grant_dc_s = 1'b0;
`ifdef MEM_ARB_RR_EN
    if (ic_req && dc_req) begin
      grant_dc_s = (rr_last_q == WIN_IC);
    end else begin
      grant_dc_s = dc_req;
    end
`else
    grant_dc_s = dc_req;
`endif
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    win_d          = win_q;
    mem_addr_d     = mem_addr_q;
    mem_op_rd_wr_d = mem_op_rd_wr_q;
    mem_wr_data_d  = mem_wr_data_q;
    mem_wr_keep_d  = mem_wr_keep_q;
    mem_op_en_d    = 1'b0;
    ic_rsp_valid_d = 1'b0;
    dc_rsp_valid_d = 1'b0;
    ic_rsp_data_d  = ic_rsp_data_q;
    dc_rsp_data_d  = dc_rsp_data_q;
`ifdef MEM_ARB_RR_EN
    rr_last_d      = rr_last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ic_req || dc_req) begin
          state_d = ST_BUSY;
          cnt_d   = LAT_LOAD;
          win_d   = grant_dc_s;
`ifdef MEM_ARB_RR_EN
          rr_last_d = grant_dc_s;
`endif
          if (grant_dc_s) begin
            mem_addr_d     = dc_addr;
            mem_op_rd_wr_d = dc_rd_wr;
            mem_wr_data_d  = dc_wr_data;
            mem_wr_keep_d  = dc_wr_keep;
          end else begin
            mem_addr_d     = ic_addr;
            mem_op_rd_wr_d = 1'b0;
            mem_wr_data_d  = {WD_SIZE{1'b0}};
            mem_wr_keep_d  = {WD_SIZE{1'b0}};
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // Counter parks at 1 rather than wrapping; it is reloaded on the next grant
        if (cnt_q <= 4'd1) begin
          state_d     = ST_ACCESS;
          mem_op_en_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        if (win_q == WIN_DC) begin
          dc_rsp_valid_d = 1'b1;
          dc_rsp_data_d  = mem_op_rd_wr_q ? {WD_SIZE{1'b0}} : mem_rd_data;
        end else begin
          ic_rsp_valid_d = 1'b1;
          ic_rsp_data_d  = mem_op_rd_wr_q ? {WD_SIZE{1'b0}} : mem_rd_data;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 4'd0;
      win_q          <= WIN_IC;
      mem_addr_q     <= {ADDR_SIZE{1'b0}};
      mem_op_rd_wr_q <= 1'b0;
      mem_op_en_q    <= 1'b0;
      mem_wr_data_q  <= {WD_SIZE{1'b0}};
      mem_wr_keep_q  <= {WD_SIZE{1'b0}};
      ic_rsp_valid_q <= 1'b0;
      dc_rsp_valid_q <= 1'b0;
      ic_rsp_data_q  <= {WD_SIZE{1'b0}};
      dc_rsp_data_q  <= {WD_SIZE{1'b0}};
      busy_q         <= 1'b0;
`ifdef MEM_ARB_RR_EN
      rr_last_q      <= WIN_IC;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      win_q          <= win_d;
      mem_addr_q     <= mem_addr_d;
      mem_op_rd_wr_q <= mem_op_rd_wr_d;
      mem_op_en_q    <= mem_op_en_d;
      mem_wr_data_q  <= mem_wr_data_d;
      mem_wr_keep_q  <= mem_wr_keep_d;
      ic_rsp_valid_q <= ic_rsp_valid_d;
      dc_rsp_valid_q <= dc_rsp_valid_d;
      ic_rsp_data_q  <= ic_rsp_data_d;
      dc_rsp_data_q  <= dc_rsp_data_d;
      busy_q         <= busy_d;
`ifdef MEM_ARB_RR_EN
      rr_last_q      <= rr_last_d;
`endif
    end
  end

  assign ic_rsp_valid = ic_rsp_valid_q;
  assign ic_rsp_data  = ic_rsp_data_q;
  assign dc_rsp_valid = dc_rsp_valid_q;
  assign dc_rsp_data  = dc_rsp_data_q;
  assign mem_addr     = mem_addr_q;
  assign mem_op_rd_wr = mem_op_rd_wr_q;
  assign mem_op_en    = mem_op_en_q;
  assign mem_wr_data  = mem_wr_data_q;
  assign mem_wr_keep  = mem_wr_keep_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a small byte-masked line memory plus a second
// instance built with MEM_LATENCY=1.
module tb_mem_arbiter;

  localparam logic [127:0] LINE40 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] INIT80 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] EXP80  = 128'h0F0E0D0C_0B0A0908_07060504_030201FF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         mem_load;
  logic         ic_req, dc_req, dc_rd_wr;
  logic [31:0]  ic_addr, dc_addr;
  logic [127:0] dc_wr_data, dc_wr_keep;
  logic         ic_rsp_valid, dc_rsp_valid;
  logic [127:0] ic_rsp_data, dc_rsp_data;
  logic [31:0]  mem_addr;
  logic         mem_op_rd_wr, mem_op_en, busy;
  logic [127:0] mem_wr_data, mem_wr_keep, mem_rd_data;

  logic         l1_ic_req;
  logic [31:0]  l1_ic_addr;
  logic         l1_dc_req, l1_dc_rd_wr;
  logic [31:0]  l1_dc_addr;
  logic [127:0] l1_dc_wr_data, l1_dc_wr_keep;
  logic         l1_ic_rsp_valid, l1_dc_rsp_valid;
  logic [127:0] l1_ic_rsp_data, l1_dc_rsp_data;
  logic [31:0]  l1_mem_addr;
  logic         l1_mem_op_rd_wr, l1_mem_op_en, l1_busy;
  logic [127:0] l1_mem_wr_data, l1_mem_wr_keep, l1_mem_rd_data;

  logic [127:0] mem [0:15];
  int total = 0;
  int bad = 0;
  int dc_log[$];
  int ic_log[$];

  mem_arbiter #(.ADDR_SIZE(32), .WD_SIZE(128), .MEM_LATENCY(5)) dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data),
    .dc_req(dc_req), .dc_rd_wr(dc_rd_wr), .dc_addr(dc_addr), .dc_wr_data(dc_wr_data),
    .dc_wr_keep(dc_wr_keep), .dc_rsp_valid(dc_rsp_valid), .dc_rsp_data(dc_rsp_data),
    .mem_addr(mem_addr), .mem_op_rd_wr(mem_op_rd_wr), .mem_op_en(mem_op_en),
    .mem_wr_data(mem_wr_data), .mem_wr_keep(mem_wr_keep), .mem_rd_data(mem_rd_data),
    .busy(busy)
  );

  mem_arbiter #(.ADDR_SIZE(32), .WD_SIZE(128), .MEM_LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .ic_req(l1_ic_req), .ic_addr(l1_ic_addr), .ic_rsp_valid(l1_ic_rsp_valid), .ic_rsp_data(l1_ic_rsp_data),
    .dc_req(l1_dc_req), .dc_rd_wr(l1_dc_rd_wr), .dc_addr(l1_dc_addr), .dc_wr_data(l1_dc_wr_data),
    .dc_wr_keep(l1_dc_wr_keep), .dc_rsp_valid(l1_dc_rsp_valid), .dc_rsp_data(l1_dc_rsp_data),
    .mem_addr(l1_mem_addr), .mem_op_rd_wr(l1_mem_op_rd_wr), .mem_op_en(l1_mem_op_en),
    .mem_wr_data(l1_mem_wr_data), .mem_wr_keep(l1_mem_wr_keep), .mem_rd_data(l1_mem_rd_data),
    .busy(l1_busy)
  );

  assign mem_rd_data    = mem[mem_addr[7:4]];
  assign l1_mem_rd_data = mem[l1_mem_addr[7:4]];

  // Line memory: only fully kept bytes are written
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 16; i++) mem[i] <= {16{8'(i) + 8'hA0}};
      mem[4] <= LINE40;
      mem[8] <= INIT80;
    end else if (mem_op_en && mem_op_rd_wr) begin
      for (int b = 0; b < 16; b++)
        if (&mem_wr_keep[b*8 +: 8]) mem[mem_addr[7:4]][b*8 +: 8] <= mem_wr_data[b*8 +: 8];
    end
  end

  // Called at the negedge of cycle 0 with a request raised; walks cycles until the response
  task automatic wait_txn(input bit want_dc, output int rsp_cyc, output int en_cyc,
                          output logic en_rw, output int en_cnt, output bit other_seen);
    rsp_cyc = -1; en_cyc = -1; en_rw = 1'bx; en_cnt = 0; other_seen = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (mem_op_en === 1'b1) begin
        en_cnt++;
        if (en_cyc < 0) begin en_cyc = c; en_rw = mem_op_rd_wr; end
      end
      if ((want_dc ? ic_rsp_valid : dc_rsp_valid) === 1'b1) other_seen = 1'b1;
      if ((want_dc ? dc_rsp_valid : ic_rsp_valid) === 1'b1) begin
        rsp_cyc = c;
        break;
      end
    end
  endtask

  // Both requesters active from cycle 0; dc drops after dc_n responses, ic after its first
  task automatic run_window(input int dc_n, input int ncyc);
    int dc_seen;
    dc_seen = 0;
    dc_log.delete();
    ic_log.delete();
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (dc_rsp_valid === 1'b1) begin
        dc_log.push_back(c);
        dc_seen++;
        if (dc_seen >= dc_n) dc_req = 1'b0;
      end
      if (ic_rsp_valid === 1'b1) begin
        ic_log.push_back(c);
        ic_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_load = 1'b1;
    ic_req = 1'b0; dc_req = 1'b0; dc_rd_wr = 1'b0;
    ic_addr = 32'h0; dc_addr = 32'h0; dc_wr_data = 128'h0; dc_wr_keep = 128'h0;
    l1_ic_req = 1'b0; l1_ic_addr = 32'h0; l1_dc_req = 1'b0; l1_dc_rd_wr = 1'b0;
    l1_dc_addr = 32'h0; l1_dc_wr_data = 128'h0; l1_dc_wr_keep = 128'h0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, mem_op_en, mem_op_rd_wr, ic_rsp_valid, dc_rsp_valid} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000", {busy, mem_op_en, mem_op_rd_wr, ic_rsp_valid, dc_rsp_valid});
    end
    total++;
    if (mem_addr !== 32'h0 || mem_wr_data !== 128'h0 || mem_wr_keep !== 128'h0) begin
      bad++; $display("FAIL reset_mem_regs: got addr=%h data=%h keep=%h want all 0", mem_addr, mem_wr_data, mem_wr_keep);
    end
    total++;
    if (ic_rsp_data !== 128'h0 || dc_rsp_data !== 128'h0) begin
      bad++; $display("FAIL reset_rsp_data: got ic=%h dc=%h want 0", ic_rsp_data, dc_rsp_data);
    end
    reset = 1'b0; mem_load = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_ic_read();
    int rc, ec, en; logic rw; bit oth;
    ic_addr = 32'h40; ic_req = 1'b1;
    wait_txn(1'b0, rc, ec, rw, en, oth);
    ic_req = 1'b0;
    total++;
    if (ec !== 6 || en !== 1) begin bad++; $display("FAIL ic_op_en: got cycle=%0d count=%0d want 6/1", ec, en); end
    total++;
    if (rw !== 1'b0) begin bad++; $display("FAIL ic_op: got %b want 0", rw); end
    total++;
    if (rc !== 7) begin bad++; $display("FAIL ic_rsp_cycle: got %0d want 7", rc); end
    total++;
    if (ic_rsp_data !== LINE40) begin bad++; $display("FAIL ic_rsp_data: got %h want %h", ic_rsp_data, LINE40); end
    total++;
    if (oth !== 1'b0) begin bad++; $display("FAIL ic_dc_quiet: got %b want 0", oth); end
    @(negedge clk);
    total++;
    if (ic_rsp_valid !== 1'b0 || ic_rsp_data !== LINE40 || busy !== 1'b0) begin
      bad++; $display("FAIL ic_after: got valid=%b busy=%b data=%h want 0/0/%h", ic_rsp_valid, busy, ic_rsp_data, LINE40);
    end
  endtask

  task automatic test_masked_write();
    int rc, ec, en; logic rw; bit oth;
    dc_addr = 32'h80; dc_rd_wr = 1'b1; dc_wr_data = {128{1'b1}}; dc_wr_keep = 128'hFF; dc_req = 1'b1;
    wait_txn(1'b1, rc, ec, rw, en, oth);
    dc_req = 1'b0;
    total++;
    if (rc !== 7 || ec !== 6 || rw !== 1'b1) begin bad++; $display("FAIL wr_timing: got rsp=%0d en=%0d op=%b want 7/6/1", rc, ec, rw); end
    total++;
    if (dc_rsp_data !== 128'h0) begin bad++; $display("FAIL wr_rsp_data: got %h want 0", dc_rsp_data); end
    total++;
    if (mem_wr_keep !== 128'hFF || oth !== 1'b0) begin bad++; $display("FAIL wr_keep: got %h ic=%b want ff/0", mem_wr_keep, oth); end
    @(negedge clk);
    dc_rd_wr = 1'b0; dc_req = 1'b1;
    wait_txn(1'b1, rc, ec, rw, en, oth);
    dc_req = 1'b0;
    total++;
    if (rc !== 7 || rw !== 1'b0) begin bad++; $display("FAIL rd_timing: got rsp=%0d op=%b want 7/0", rc, rw); end
    total++;
    if (dc_rsp_data !== EXP80) begin bad++; $display("FAIL rd_merged: got %h want %h", dc_rsp_data, EXP80); end
    @(negedge clk);
    ic_addr = 32'h80; ic_req = 1'b1;
    wait_txn(1'b0, rc, ec, rw, en, oth);
    ic_req = 1'b0;
    total++;
    if (rc !== 7 || ic_rsp_data !== EXP80) begin bad++; $display("FAIL ic_rd80: got rsp=%0d data=%h want 7/%h", rc, ic_rsp_data, EXP80); end
    total++;
    if (mem_wr_keep !== 128'h0 || mem_op_rd_wr !== 1'b0) begin
      bad++; $display("FAIL ic_latch: got keep=%h op=%b want 0/0", mem_wr_keep, mem_op_rd_wr);
    end
    @(negedge clk);
  endtask

  task automatic test_tie();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    ic_addr = 32'h40; dc_addr = 32'h80; dc_rd_wr = 1'b0;
    ic_req = 1'b1; dc_req = 1'b1;
`ifdef MEM_ARB_RR_EN
    run_window(2, 30);
    total++;
    if (dc_log.size() != 2 || dc_log[0] != 7 || dc_log[1] != 23) begin
      bad++; $display("FAIL rr_dc_order: got n=%0d first=%0d want 2 at 7,23", dc_log.size(), (dc_log.size() > 0) ? dc_log[0] : -1);
    end
    total++;
    if (ic_log.size() != 1 || ic_log[0] != 15) begin
      bad++; $display("FAIL rr_ic_order: got n=%0d first=%0d want 1 at 15", ic_log.size(), (ic_log.size() > 0) ? ic_log[0] : -1);
    end
`else
    run_window(5, 50);
    total++;
    if (dc_log.size() != 5 || dc_log[0] != 7 || dc_log[1] != 15 || dc_log[2] != 23 || dc_log[3] != 31 || dc_log[4] != 39) begin
      bad++; $display("FAIL fp_dc_order: got n=%0d first=%0d want 5 at 7..39", dc_log.size(), (dc_log.size() > 0) ? dc_log[0] : -1);
    end
    total++;
    if (ic_log.size() != 1 || ic_log[0] != 47) begin
      bad++; $display("FAIL fp_ic_starve: got n=%0d first=%0d want 1 at 47", ic_log.size(), (ic_log.size() > 0) ? ic_log[0] : -1);
    end
`endif
    total++;
    if (ic_rsp_data !== LINE40 || dc_rsp_data !== EXP80) begin
      bad++; $display("FAIL tie_data: got ic=%h dc=%h want %h %h", ic_rsp_data, dc_rsp_data, LINE40, EXP80);
    end
  endtask

  task automatic test_reset_mid();
    int rc, ec, en, noise; logic rw; bit oth;
    dc_addr = 32'h40; dc_rd_wr = 1'b0; dc_req = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || mem_op_en !== 1'b0 || dc_rsp_valid !== 1'b0 || mem_addr !== 32'h0) begin
      bad++; $display("FAIL mid_reset: got busy=%b en=%b rsp=%b addr=%h want 0", busy, mem_op_en, dc_rsp_valid, mem_addr);
    end
    total++;
    if (dc_rsp_data !== 128'h0 || ic_rsp_data !== 128'h0) begin
      bad++; $display("FAIL mid_rsp_data: got dc=%h ic=%h want 0", dc_rsp_data, ic_rsp_data);
    end
    reset = 1'b0; dc_req = 1'b0;
    noise = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem_op_en !== 1'b0 || dc_rsp_valid !== 1'b0 || ic_rsp_valid !== 1'b0 || busy !== 1'b0) noise++;
    end
    total++;
    if (noise != 0) begin bad++; $display("FAIL abandoned: got %0d active cycles want 0", noise); end
    ic_addr = 32'h40; ic_req = 1'b1;
    wait_txn(1'b0, rc, ec, rw, en, oth);
    ic_req = 1'b0;
    total++;
    if (rc !== 7 || ic_rsp_data !== LINE40) begin bad++; $display("FAIL post_reset_ic: got rsp=%0d data=%h want 7/%h", rc, ic_rsp_data, LINE40); end
    @(negedge clk);
  endtask

  task automatic test_latency1();
    int ec, rc;
    ec = -1; rc = -1;
    l1_ic_addr = 32'h40; l1_ic_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (l1_mem_op_en === 1'b1 && ec < 0) ec = c;
      if (l1_ic_rsp_valid === 1'b1) begin rc = c; break; end
    end
    l1_ic_req = 1'b0;
    total++;
    if (ec !== 2 || rc !== 3) begin bad++; $display("FAIL lat1_timing: got en=%0d rsp=%0d want 2/3", ec, rc); end
    total++;
    if (l1_ic_rsp_data !== LINE40) begin bad++; $display("FAIL lat1_data: got %h want %h", l1_ic_rsp_data, LINE40); end
  endtask

  initial begin
    test_reset();
    test_ic_read();
    test_masked_write();
    test_tie();
    test_reset_mid();
    test_latency1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
